piso_bit_serializer: RTL and testbench

- Upstream feeder for the serial Mealy sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `x`.
- `x` connects directly to the detector's serial input; `x_valid` qualifies each bit.
- Between words the line idles at a fixed level, so the detector sees a well-defined stream.

---
 rtl/piso_bit_serializer.sv | 145 ++++++++++++++
 tb/tb_piso_bit_serializer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out bit serializer feeding the serial sequence detector.
// It accepts a word over a valid/ready handshake and emits it one bit per clock on x.
// x_valid qualifies each bit, and done marks the final bit of each word.
// Between words, x idles at IDLE_BIT for GAP cycles.
// Optional feature macro SER_PARITY_EN adds one even-parity bit after the data bits.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

`ifdef SER_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  // Total bits on the line per word, including parity when enabled.
  localparam int unsigned LAST     = WIDTH + PAR_BITS;
  localparam int unsigned CNT_W    = $clog2(LAST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
  localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gap;
  logic             r_x;
  logic             r_xv;
  logic             r_done;
  logic             r_busy;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif

  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_sr;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_sr;
  logic [CNT_W-1:0] w_cnt_inc;

  // Handshake and shift-path decode.
  // The last-bit cycle can accept a new word only when no gap is configured.
  always_comb begin
    w_last     = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
    w_ready    = rst && ((r_state == S_IDLE) || (w_last && (GAP == 0)));
    w_accept   = din_valid && w_ready;
    w_load_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    w_load_sr  = MSB_FIRST ? (din << 1) : (din >> 1);
    w_next_sr  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
    w_cnt_inc  = r_cnt + 1'b1;
`ifdef SER_PARITY_EN
    // After all data bits have been shifted out, the parity bit goes on the line.
    if (r_cnt == CNT_W'(WIDTH)) w_next_bit = r_par;
    else                        w_next_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
`else
    w_next_bit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
`endif
  end

  // Serializer FSM with registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_x     <= IDLE_BIT;
      r_xv    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      // Load from IDLE, or back-to-back on the last bit when GAP is 0.
      r_state <= S_SHIFT;
      r_sr    <= w_load_sr;
      r_cnt   <= CNT_W'(1);
      r_x     <= w_load_bit;
      r_xv    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
`ifdef SER_PARITY_EN
      r_par   <= ^din;
`endif
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          if (!w_last) begin
            r_x    <= w_next_bit;
            r_sr   <= w_next_sr;
            r_cnt  <= w_cnt_inc;
            r_done <= (w_cnt_inc == LAST_CNT);
          end else begin
            r_x    <= IDLE_BIT;
            r_xv   <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            if (GAP == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
              r_gap   <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign din_ready = w_ready;
  assign x         = r_x;
  assign x_valid   = r_xv;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Randomized self-checking bench for piso_bit_serializer.
// It runs three configurations: the defaults, LSB-first, and GAP=0.
// A bit-list reference model checks all outputs once per cycle.
module tb_piso_bit_serializer;
  localparam int N = 3;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din [N];
  logic       dv  [N];
  logic       rdy [N];
  logic       x   [N];
  logic       xv  [N];
  logic       bsy [N];
  logic       dn  [N];

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP(1)) u_dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .x(x[0]), .x_valid(xv[0]), .busy(bsy[0]), .done(dn[0]));
  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .x(x[1]), .x_valid(xv[1]), .busy(bsy[1]), .done(dn[1]));
  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
    .x(x[2]), .x_valid(xv[2]), .busy(bsy[2]), .done(dn[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the bits of the current word in line order, plus an index and a gap count.
  logic [8:0] m_bits [N];
  int         m_len  [N];
  int         m_idx  [N];
  int         m_gap  [N];
  bit         m_v    [N];
  bit         m_x    [N];
  bit         m_d    [N];
  bit         m_acc  [N];

  function automatic int gap_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 1);
  endfunction

  function automatic bit m_ready(input int k);
    return rst && ((!m_v[k] && m_gap[k] == 0) ||
                   (m_v[k] && m_idx[k] == m_len[k] - 1 && gap_of(k) == 0));
  endfunction

  task automatic m_reset(input int k);
    m_v[k] = 0; m_x[k] = 1; m_d[k] = 0; m_gap[k] = 0;
    m_idx[k] = 0; m_len[k] = 0; m_acc[k] = 0; m_bits[k] = '0;
  endtask

  task automatic m_load(input int k, input logic [7:0] w);
    for (int i = 0; i < 8; i++) m_bits[k][i] = msb_of(k) ? w[7-i] : w[i];
    if (PAR == 1) m_bits[k][8] = ^w;
    m_len[k] = 8 + PAR;
    m_idx[k] = 0;
    m_x[k]   = m_bits[k][0];
    m_v[k]   = 1;
    m_d[k]   = 0;
  endtask

  // Advance the model by one clock edge.
  task automatic m_step(input int k);
    bit acc;
    acc = dv[k] && m_ready(k);
    m_acc[k] = acc;
    if (m_v[k] && m_idx[k] < m_len[k] - 1) begin
      m_idx[k]++;
      m_x[k] = m_bits[k][m_idx[k]];
      m_d[k] = (m_idx[k] == m_len[k] - 1);
    end else if (m_v[k]) begin
      if (acc) m_load(k, din[k]);
      else begin
        m_v[k] = 0; m_x[k] = 1; m_d[k] = 0;
        m_gap[k] = gap_of(k);
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end else if (acc) begin
      m_load(k, din[k]);
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    for (int k = 0; k < N; k++) begin
      obs = {x[k], xv[k], dn[k], bsy[k], rdy[k]};
      exp = {m_x[k], m_v[k], m_d[k], (m_v[k] || m_gap[k] > 0), m_ready(k)};
      check_eq($sformatf("%s[%0d] {x,xv,done,busy,rdy}", tag, k), {27'd0, obs}, {27'd0, exp});
    end
  endtask

  // Directed words lead each channel; after that, stimulus is random.
  logic [7:0] s0[$];
  logic [7:0] s1[$];
  logic [7:0] s2[$];

  task automatic produce();
    bit         got;
    logic [7:0] w;
    for (int k = 0; k < N; k++) begin
      if (m_acc[k] || !dv[k]) begin
        got = 0;
        w   = '0;
        case (k)
          0: if (s0.size() > 0) begin w = s0.pop_front(); got = 1; end
          1: if (s1.size() > 0) begin w = s1.pop_front(); got = 1; end
          default: if (s2.size() > 0) begin w = s2.pop_front(); got = 1; end
        endcase
        if (got) begin
          din[k] = w; dv[k] = 1'b1;
        end else begin
          dv[k]  = ($urandom_range(3) != 0);
          din[k] = 8'($urandom);
        end
      end else if (!m_ready(k)) begin
        // Scramble a pending word while it cannot be accepted; only the value at acceptance counts.
        din[k] = 8'($urandom);
      end
    end
  endtask

  bit did_rst = 0;

  initial begin
    s0 = '{8'hB4, 8'h07};
    s1 = '{8'hB4, 8'h07};
    s2 = '{8'hFF, 8'h00, 8'hB4, 8'h07};
    for (int k = 0; k < N; k++) begin
      dv[k] = 1'b0; din[k] = '0;
      m_reset(k);
    end
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    produce();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      for (int k = 0; k < N; k++) m_step(k);
      @(negedge clk);
      check_all("run");
      if (!did_rst && cyc >= 200 && m_v[0] && m_idx[0] == 3) begin
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) m_reset(k);
        check_all("rst_mid");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b1;
        did_rst = 1;
        #1;
        check_all("rst_rel");
      end
      produce();
    end
    check_eq("rst_mid_reached", {31'd0, did_rst}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
